cdp_sum_pipe_arb: RTL and testbench
===================================

Name: cdp_sum_pipe_arb

Overview:
- Round-robin, packet-locking arbiter that shares one CDP sum-block output pipe stage among NUM_REQ fp16 partial-sum lanes.
- Each lane has a valid/ready/payload interface plus a last flag.
- The winning lane's beats pass through one registered valid/ready stage, with the same semantics as the sum-block pipe stages.
- Sits between the per-lane fp16 dout pipes and the downstream accumulate stage.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- PD_W, 32, payload width per lane.
- SRC_W, $clog2(NUM_REQ), width of source-id field.

Ports:
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- req_vld  in  NUM_REQ  per-lane valid.
- req_last  in  NUM_REQ  per-lane last-beat-of-packet flag, qualified by req_vld.
- req_pd  in  NUM_REQ*PD_W  per-lane payload; lane i at [i*PD_W +: PD_W].
- req_rdy  out  NUM_REQ  per-lane ready.
- out_vld  out  1  output stage valid.
- out_pd  out  PD_W  output payload.
- out_src  out  SRC_W  lane index of out_pd.
- out_last  out  1  last flag of the current output beat.
- out_rdy  in  1  downstream ready.
- perf_stall_cnt  out  NUM_REQ*16  per-lane stall counters (see Optional Feature).

Behaviour:
- Reset values:
  - out_vld=0, lock=0, lock_id=0, rr_ptr=NUM_REQ-1 (lane 0 wins first), perf counters=0.
  - out_pd, out_src and out_last are data registers and are not reset; they are valid only when out_vld=1.
- Output stage:
  - ready_bc = out_rdy | ~out_vld.
  - out_vld_next = ready_bc ? any_grant_vld : 1.
  - When ready_bc and a granted lane is valid, load out_pd, out_src and out_last from that lane; otherwise hold.
  - Latency is one cycle from the accepted req beat to out_vld.
  - Full throughput: one beat per cycle when out_rdy is held high.
- Grant (combinational):
  - lock=1: grant is one-hot on lock_id only. Other lanes see req_rdy=0 even if valid.
  - lock=0: grant goes to the first valid lane scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - No valid lane: grant=0.
- req_rdy[i] = ready_bc & grant[i]. At most one req_rdy is high per cycle. req_rdy does not depend on req_vld of other lanes while locked.
- Beat accepted = req_vld[g] & req_rdy[g].
- States IDLE (lock=0) and LOCK (lock=1):
  - IDLE, accepted beat with last=0 → LOCK, lock_id=g.
  - IDLE, accepted beat with last=1 → stay IDLE, rr_ptr=g.
  - LOCK, accepted beat with last=1 → IDLE, rr_ptr=lock_id.
  - LOCK, accepted beat with last=0, or no accept → stay LOCK.
- rr_ptr updates only on a last-beat accept; a single-beat packet counts as one packet.
- A locked lane that deasserts valid keeps the lock; the output stalls (bubbles) and no other lane is served.
- Simultaneous out_rdy=0 and out_vld=1: all req_rdy=0; out_* holds stable.
- Asynchronous reset mid-packet: lock and out_vld clear immediately. The partial packet is dropped; upstream must also be reset.

Optional Feature:
- Macro CDP_SUM_PIPE_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt[i] is a 16-bit saturating counter (stops at 0xFFFF).
  - It increments each cycle req_vld[i]=1 and req_rdy[i]=0.
  - Reset to 0 by nvdla_core_rstn only.
- Undefined: no counter flops; perf_stall_cnt tied to 0.

Decomposition:
- Package cdp_sum_arb_pkg holds:
  - defaults for NUM_REQ and PD_W;
  - state enum {ARB_IDLE, ARB_LOCK};
  - constant PERF_CNT_W=16.
- One sub-module: cdp_sum_rr_pick, a combinational round-robin picker.
  - Inputs: vld vector, rr_ptr.
  - Outputs: one-hot grant, encoded index.
  - Instantiated once; the lock override is applied in the parent.

Test Plan:
- Reset, then all four lanes valid with last=1, out_rdy=1 → out_src sequence 0,1,2,3,0 on consecutive cycles; out_vld first high one cycle after the first accept.
- Lane 2 sends a 3-beat packet (pd 0xA0,0xA1,0xA2, last on the third) while lanes 0/1/3 are valid → out_src=2 for three consecutive beats; lanes 0/1/3 req_rdy=0 throughout; next grant goes to lane 3.
- out_rdy=0 for 5 cycles with out_vld=1 and pd 0x1234 → out_pd holds 0x1234, all req_rdy=0; on out_rdy=1 the next beat follows with no loss or duplication.
- Locked lane 1 drops valid for 2 cycles mid-packet while lane 0 is valid → 2 output bubbles, lane 0 not granted until lane 1's last beat.
- Assert nvdla_core_rstn low mid-packet while locked on lane 3 → out_vld=0 immediately; after release, lane 0 wins first arbitration.
- With CDP_SUM_PIPE_ARB_PERF_EN, hold lane 2 valid while blocked for 70000 cycles → perf_stall_cnt lane 2 = 0xFFFF.

Source files
------------

// File: rtl/cdp_sum_pipe_arb_pkg.sv
// Shared defaults and types for the CDP sum-pipe round-robin arbiter.
// The optional stall counters are enabled by CDP_SUM_PIPE_ARB_PERF_EN.
package cdp_sum_arb_pkg;
  localparam int unsigned CDP_SUM_NUM_REQ = 4;
  localparam int unsigned CDP_SUM_PD_W    = 32;
  localparam int unsigned PERF_CNT_W      = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;
endpackage

// File: rtl/cdp_sum_pipe_arb_if.sv
// Lane request bus, output stage bus and perf counters of the sum-pipe arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipe.
interface cdp_sum_pipe_arb_if
  import cdp_sum_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = CDP_SUM_NUM_REQ,
  parameter int unsigned PD_W    = CDP_SUM_PD_W,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*PD_W-1:0]       req_pd;
  logic [NUM_REQ-1:0]            req_rdy;
  logic                          out_vld;
  logic [PD_W-1:0]               out_pd;
  logic [SRC_W-1:0]              out_src;
  logic                          out_last;
  logic                          out_rdy;
  logic [NUM_REQ*PERF_CNT_W-1:0] perf_stall_cnt;

  modport master (
    output req_vld, req_last, req_pd, out_rdy,
    input  req_rdy, out_vld, out_pd, out_src, out_last, perf_stall_cnt
  );

  modport slave (
    input  req_vld, req_last, req_pd, out_rdy,
    output req_rdy, out_vld, out_pd, out_src, out_last, perf_stall_cnt
  );
endinterface

// File: rtl/cdp_sum_pipe_arb_rr_pick.sv
// Combinational round-robin picker: first valid lane after rr_ptr_i, wrapping.
// Produces a one-hot grant and its encoded index (both zero when nothing is valid).
module cdp_sum_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] vld_i,
  input  logic [SRC_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SRC_W-1:0]   idx_o
);
  always_comb begin
    logic           found;
    logic [SRC_W:0] cand;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr_i} + (SRC_W+1)'(off);
      if (cand >= (SRC_W+1)'(NUM_REQ)) cand = cand - (SRC_W+1)'(NUM_REQ);
      if (!found && vld_i[cand[SRC_W-1:0]]) begin
        found                      = 1'b1;
        grant_o[cand[SRC_W-1:0]]   = 1'b1;
        idx_o                      = cand[SRC_W-1:0];
      end
    end
  end
endmodule

// File: rtl/cdp_sum_pipe_arb.sv
// Packet-locking round-robin arbiter feeding one registered valid/ready stage.
// Per-lane stall counters exist only when CDP_SUM_PIPE_ARB_PERF_EN is defined.
module cdp_sum_pipe_arb
  import cdp_sum_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = CDP_SUM_NUM_REQ,
  parameter int unsigned PD_W    = CDP_SUM_PD_W,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  cdp_sum_pipe_arb_if.slave  arb_if
);
  arb_state_e         state_q, state_d;
  logic [SRC_W-1:0]   lock_id_q, lock_id_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_vld_q, out_vld_d;
  logic [PD_W-1:0]    out_pd_q;
  logic [SRC_W-1:0]   out_src_q;
  logic               out_last_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [SRC_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   sel_idx;
  logic [PD_W-1:0]    sel_pd;
  logic               sel_last;
  logic               ready_bc;
  logic               any_grant_vld;
  logic               accept;
  logic [NUM_REQ-1:0] req_rdy;

  cdp_sum_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .vld_i    (arb_if.req_vld),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx)
  );

  // While locked the grant ignores req_vld so the owner keeps the pipe through bubbles.
  always_comb begin
    grant   = pick_grant;
    sel_idx = pick_idx;
    if (state_q == ARB_LOCK) begin
      grant            = '0;
      grant[lock_id_q] = 1'b1;
      sel_idx          = lock_id_q;
    end
  end

  always_comb begin
    sel_pd   = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_pd   = sel_pd | arb_if.req_pd[i*PD_W +: PD_W];
        sel_last = sel_last | arb_if.req_last[i];
      end
    end
  end

  assign ready_bc      = arb_if.out_rdy | ~out_vld_q;
  assign any_grant_vld = |(grant & arb_if.req_vld);
  assign accept        = ready_bc & any_grant_vld;
  assign req_rdy       = {NUM_REQ{ready_bc}} & grant;
  assign out_vld_d     = ready_bc ? any_grant_vld : 1'b1;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      if (state_q == ARB_IDLE) begin
        if (sel_last) begin
          rr_ptr_d = sel_idx;
        end else begin
          state_d   = ARB_LOCK;
          lock_id_d = sel_idx;
        end
      end else if (sel_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = lock_id_q;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= SRC_W'(NUM_REQ - 1);
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (accept) begin
      out_pd_q   <= sel_pd;
      out_src_q  <= sel_idx;
      out_last_q <= sel_last;
    end
  end

  assign arb_if.req_rdy  = req_rdy;
  assign arb_if.out_vld  = out_vld_q;
  assign arb_if.out_pd   = out_pd_q;
  assign arb_if.out_src  = out_src_q;
  assign arb_if.out_last = out_last_q;

`ifdef CDP_SUM_PIPE_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] stall_q [NUM_REQ];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) stall_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (arb_if.req_vld[i] && !req_rdy[i] && !(&stall_q[i]))
          stall_q[i] <= stall_q[i] + PERF_CNT_W'(1);
      end
    end
  end

  always_comb begin
    arb_if.perf_stall_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      arb_if.perf_stall_cnt[i*PERF_CNT_W +: PERF_CNT_W] = stall_q[i];
  end
`else
  assign arb_if.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_cdp_sum_pipe_arb.sv
// Bench for cdp_sum_pipe_arb: packet-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdp_sum_pipe_arb;
  import cdp_sum_arb_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cdp_sum_pipe_arb_if #(.NUM_REQ(N), .PD_W(W)) bus ();

  cdp_sum_pipe_arb #(.NUM_REQ(N), .PD_W(W)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .arb_if          (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: one output slot, current packet owner, lane of the last finished packet.
  bit          m_vld;
  logic [W-1:0] m_pd;
  int          m_src;
  bit          m_last;
  int          m_owner;
  int          m_prev;
  int unsigned m_stall [N];

  function automatic void m_reset();
    m_vld   = 1'b0;
    m_owner = -1;
    m_prev  = N - 1;
    for (int i = 0; i < N; i++) m_stall[i] = 0;
  endfunction

  initial m_reset();

  always @(negedge clk) begin
    int          lane;
    int          c;
    bit          rbc;
    bit          acc;
    logic [N-1:0] exp_rdy;
    if (!rstn) m_reset();
    check("out_vld", bus.out_vld, m_vld);
    if (m_vld) begin
      check("out_pd", bus.out_pd, m_pd);
      check("out_src", bus.out_src, m_src);
      check("out_last", bus.out_last, m_last);
    end
    rbc  = bus.out_rdy || !m_vld;
    lane = -1;
    if (m_owner >= 0) lane = m_owner;
    else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_prev + k) % N;
        if (lane < 0 && bus.req_vld[c]) lane = c;
      end
    end
    exp_rdy = '0;
    if (rbc && lane >= 0) exp_rdy[lane] = 1'b1;
    check("req_rdy", bus.req_rdy, exp_rdy);
    for (int i = 0; i < N; i++)
      check("perf_cnt", bus.perf_stall_cnt[i*16 +: 16], m_stall[i]);
    if (rstn) begin
`ifdef CDP_SUM_PIPE_ARB_PERF_EN
      for (int i = 0; i < N; i++)
        if (bus.req_vld[i] && !exp_rdy[i] && m_stall[i] < 65535) m_stall[i]++;
`endif
      acc = rbc && lane >= 0 && bus.req_vld[lane];
      if (acc) begin
        m_pd   = bus.req_pd[lane*W +: W];
        m_src  = lane;
        m_last = bus.req_last[lane];
        if (m_last) begin
          m_owner = -1;
          m_prev  = lane;
        end else begin
          m_owner = lane;
        end
      end
      if (rbc) m_vld = acc;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [N*W-1:0] pd, input logic ordy);
    bus.req_vld  = v;
    bus.req_last = l;
    bus.req_pd   = pd;
    bus.out_rdy  = ordy;
  endtask

  task automatic do_reset();
    next();
    rstn = 1'b0;
    drive('0, '0, '0, 1'b1);
    repeat (2) next();
    rstn = 1'b1;
  endtask

  int s1_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive('0, '0, '0, 1'b1);
    mid();
    check("rst_out_vld", bus.out_vld, 1'b0);
    check("rst_req_rdy", bus.req_rdy, 4'b0000);

    // Plain rotation with single-beat packets.
    do_reset();
    drive(4'hF, 4'hF, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b1);
    mid();
    check("s1_first_lat", bus.out_vld, 1'b0);
    for (int k = 0; k < 5; k++) begin
      mid();
      check("s1_vld", bus.out_vld, 1'b1);
      check("s1_src", bus.out_src, s1_exp[k]);
    end

    // Lane 2 locks for a 3-beat packet, then lane 3 is next.
    do_reset();
    drive(4'b0010, 4'b0010, {32'h0, 32'h0, 32'h11, 32'h0}, 1'b1);
    mid();
    check("s2_pre_rdy", bus.req_rdy, 4'b0010);
    next();
    drive(4'b1111, 4'b1011, {32'h33, 32'hA0, 32'h11, 32'h0F}, 1'b1);
    mid();
    check("s2_rdy_a0", bus.req_rdy, 4'b0100);
    next();
    drive(4'b1111, 4'b1011, {32'h33, 32'hA1, 32'h11, 32'h0F}, 1'b1);
    mid();
    check("s2_pd_a0", bus.out_pd, 32'hA0);
    check("s2_src_a0", bus.out_src, 2'd2);
    check("s2_rdy_a1", bus.req_rdy, 4'b0100);
    next();
    drive(4'b1111, 4'b1111, {32'h33, 32'hA2, 32'h11, 32'h0F}, 1'b1);
    mid();
    check("s2_pd_a1", bus.out_pd, 32'hA1);
    check("s2_rdy_a2", bus.req_rdy, 4'b0100);
    next();
    drive(4'b1011, 4'b1011, {32'h33, 32'h00, 32'h11, 32'h0F}, 1'b1);
    mid();
    check("s2_pd_a2", bus.out_pd, 32'hA2);
    check("s2_last_a2", bus.out_last, 1'b1);
    check("s2_rdy_after", bus.req_rdy, 4'b1000);
    mid();
    check("s2_next_src", bus.out_src, 2'd3);

    // Downstream stall holds the output and blocks all lanes.
    do_reset();
    drive(4'b0001, 4'b0001, {96'h0, 32'h1234}, 1'b1);
    next();
    drive(4'b0001, 4'b0001, {96'h0, 32'h5678}, 1'b0);
    for (int k = 0; k < 5; k++) begin
      mid();
      check("s3_hold_pd", bus.out_pd, 32'h1234);
      check("s3_hold_vld", bus.out_vld, 1'b1);
      check("s3_hold_rdy", bus.req_rdy, 4'b0000);
      next();
    end
    bus.out_rdy = 1'b1;
    mid();
    check("s3_rel_pd", bus.out_pd, 32'h1234);
    check("s3_rel_rdy", bus.req_rdy, 4'b0001);
    next();
    bus.req_vld = 4'b0000;
    mid();
    check("s3_next_pd", bus.out_pd, 32'h5678);
    next();
    mid();
    check("s3_no_dup", bus.out_vld, 1'b0);

    // Locked lane 1 bubbles for two cycles; lane 0 waits for its last beat.
    do_reset();
    drive(4'b0010, 4'b0000, {32'h0, 32'h0, 32'hB0, 32'h0}, 1'b1);
    next();
    drive(4'b0001, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hD0}, 1'b1);
    mid();
    check("s4_pd_b0", bus.out_pd, 32'hB0);
    check("s4_rdy_lock", bus.req_rdy, 4'b0010);
    next();
    mid();
    check("s4_bubble1", bus.out_vld, 1'b0);
    next();
    drive(4'b0011, 4'b0011, {32'h0, 32'h0, 32'hB1, 32'hD0}, 1'b1);
    mid();
    check("s4_bubble2", bus.out_vld, 1'b0);
    check("s4_rdy_held", bus.req_rdy, 4'b0010);
    next();
    drive(4'b0001, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hD0}, 1'b1);
    mid();
    check("s4_pd_b1", bus.out_pd, 32'hB1);
    check("s4_rdy_free", bus.req_rdy, 4'b0001);
    next();
    mid();
    check("s4_src_l0", bus.out_src, 2'd0);

    // Asynchronous reset while locked on lane 3.
    do_reset();
    drive(4'b1000, 4'b0000, {32'hC0, 96'h0}, 1'b1);
    next();
    drive(4'b1001, 4'b0000, {32'hC1, 64'h0, 32'hE0}, 1'b1);
    mid();
    check("s5_pre_vld", bus.out_vld, 1'b1);
    check("s5_pre_src", bus.out_src, 2'd3);
    #2;
    rstn = 1'b0;
    #1;
    check("s5_async_clr", bus.out_vld, 1'b0);
    next();
    drive(4'b1001, 4'b1001, {32'hC2, 64'h0, 32'hE0}, 1'b1);
    next();
    rstn = 1'b1;
    mid();
    check("s5_rdy_l0", bus.req_rdy, 4'b0001);
    next();
    mid();
    check("s5_src_l0", bus.out_src, 2'd0);

    // Randomized traffic against the model.
    do_reset();
    repeat (3000) begin
      drive(N'($urandom), N'($urandom & $urandom),
            {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) != 0));
      next();
    end

`ifdef CDP_SUM_PIPE_ARB_PERF_EN
    do_reset();
    drive(4'b0101, 4'b0000, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    repeat (70000) next();
    mid();
    check("perf_sat_l2", bus.perf_stall_cnt[2*16 +: 16], 16'hFFFF);
    check("perf_l0_zero", bus.perf_stall_cnt[0 +: 16], 16'h0000);
`else
    drive(4'b0101, 4'b0000, '0, 1'b0);
    repeat (4) next();
    mid();
    check("perf_tied_zero", bus.perf_stall_cnt, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
